// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I fetch stage with PC, one-outstanding imem port and a 2-entry decode FIFO.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky HALT state.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc4,
  output logic        misalign_err
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH, WAIT, DROP, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
`endif

  state_t      state_q, state_d, idle_state;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic        head_q, head_d, tail;
  logic [1:0]  count_q, count_d, count_after;
  logic        redir, push, pop, issue;
  logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d, trap;
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    redir      = redirect_en && (state_q != HALT);
    target_pc  = redirect_pc;
    trap       = redir && (redirect_pc[1:0] != 2'b00);
    misalign_d = misalign_q | trap;
    idle_state = (misalign_q || trap) ? HALT : FETCH;
`else
    redir      = redirect_en;
    target_pc  = redirect_pc & 32'hFFFF_FFFC;
    idle_state = FETCH;
`endif

    dec_valid   = (count_q != 2'd0);
    dec_instr   = dec_valid ? fifo_instr_q[head_q] : NOP_INSTR;
    dec_pc      = dec_valid ? fifo_pc_q[head_q] : last_pc_q;
    dec_pc4     = dec_pc + 32'd4;

    pop         = dec_valid && dec_ready;
    push        = (state_q == WAIT) && imem_rvalid && !redir;
    count_after = count_q + {1'b0, push} - {1'b0, pop};
    issue       = !reset && !redirect_en && (count_after < 2'd2) &&
                  ((state_q == FETCH) || ((state_q == WAIT) && imem_rvalid));
    imem_req    = issue;
    imem_addr   = pc_q;

    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    last_pc_d    = dec_pc;
    head_d       = head_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    // With count 2 the tail slot equals the head being popped this cycle.
    tail         = head_q ^ (count_q == 2'd1);

    if (issue) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end

    if (redir) begin
      pc_d    = target_pc;
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        fifo_pc_d[tail]    = req_pc_q;
        fifo_instr_d[tail] = imem_rdata;
      end
      if (pop) head_d = ~head_q;
      count_d = count_after;
    end

    case (state_q)
      FETCH:   state_d = redir ? idle_state : (issue ? WAIT : FETCH);
      WAIT: begin
        if (redir)            state_d = imem_rvalid ? idle_state : DROP;
        else if (imem_rvalid) state_d = issue ? WAIT : FETCH;
      end
      // A response arriving alongside a redirect still ends the outstanding request.
      DROP:    if (imem_rvalid) state_d = idle_state;
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT:    state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      last_pc_q    <= 32'd0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
      fifo_pc_q    <= '{default: 32'd0};
      fifo_instr_q <= '{default: 32'd0};
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      last_pc_q    <= last_pc_d;
      head_q       <= head_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a transaction-level
// fetch model (sequential PC stream, epoch-tagged memory responses, buffer occupancy).
module tb_ifetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;
  logic        misalign_err;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc4(dec_pc4),
    .misalign_err(misalign_err)
  );

  int checks = 0;
  int failures = 0;

  // Memory model: one outstanding read, fixed latency, data = address + 0x100.
  int          mem_lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  int          mem_tag = 0;
  logic [31:0] mem_addr = 32'd0;

  // Fetch model: next request address, next PC owed to decode, buffered count.
  int          epoch = 0;
  int          occ = 0;
  bit          model_halt = 1'b0;
  logic [31:0] exp_req_addr = RESET_PC;
  logic [31:0] exp_dec_pc = RESET_PC;
  logic [31:0] exp_last_pc = 32'd0;

  logic        obs_req, obs_dvalid, obs_err;
  logic [31:0] obs_addr, obs_dpc, obs_dpc4, obs_instr;

  function automatic logic [31:0] target_of(input logic [31:0] p);
`ifdef FETCH_MISALIGN_TRAP_EN
    return p;
`else
    return p & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs, check against the model, advance the model.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic        pop, kept;
    int          after;
    logic [31:0] shown_pc;
    dec_ready   = rdy;
    redirect_en = redir;
    redirect_pc = rpc;
    imem_rvalid = mem_busy && (mem_wait == 0);
    imem_rdata  = imem_rvalid ? mem_addr + 32'h100 : 32'hDEAD_BEEF;
    #1;
    obs_req = imem_req;   obs_addr = imem_addr; obs_dvalid = dec_valid;
    obs_dpc = dec_pc;     obs_dpc4 = dec_pc4;   obs_instr  = dec_instr;
    obs_err = misalign_err;

    shown_pc = (occ > 0) ? exp_dec_pc : exp_last_pc;
    checkOutput("dec_valid", 32'(obs_dvalid), 32'(occ > 0));
    checkOutput("dec_pc", obs_dpc, shown_pc);
    checkOutput("dec_pc4", obs_dpc4, shown_pc + 32'd4);
    checkOutput("dec_instr", obs_instr, (occ > 0) ? shown_pc + 32'h100 : NOP_INSTR);
    checkOutput("imem_addr", obs_addr, exp_req_addr);
    checkOutput("misalign_err", 32'(obs_err), 32'(model_halt));

    pop   = (occ > 0) && rdy;
    kept  = imem_rvalid && !redir && (mem_tag == epoch);
    after = occ + int'(kept) - int'(pop);
    if (redir || model_halt || (mem_busy && !imem_rvalid) ||
        (imem_rvalid && mem_tag != epoch) || after >= 2)
      checkOutput("no_issue", 32'(obs_req), 32'd0);

    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (obs_req) begin
      mem_busy = 1'b1; mem_wait = mem_lat - 1; mem_addr = obs_addr; mem_tag = epoch;
      exp_req_addr = exp_req_addr + 32'd4;
    end
    exp_last_pc = shown_pc;
    if (redir) begin
      occ = 0;
      epoch++;
      exp_req_addr = target_of(rpc);
      exp_dec_pc   = target_of(rpc);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) model_halt = 1'b1;
`endif
    end else begin
      occ = after;
      if (pop) exp_dec_pc = exp_dec_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1; dec_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_dec_valid", 32'(dec_valid), 32'd0);
    checkOutput("rst_dec_instr", dec_instr, NOP_INSTR);
    checkOutput("rst_dec_pc", dec_pc, 32'd0);
    checkOutput("rst_dec_pc4", dec_pc4, 32'd4);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    mem_busy = 1'b0; occ = 0; epoch++; model_halt = 1'b0;
    exp_req_addr = RESET_PC; exp_dec_pc = RESET_PC; exp_last_pc = 32'd0;
    reset = 1'b0;
  endtask

  initial begin
    logic        r_rdy, r_redir;
    logic [31:0] r_pc;
    bit          seen;

    // Reset release and 1-cycle memory pipeline fill.
    mem_lat = 1;
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_req0", 32'(obs_req), 32'd1);
    checkOutput("t1_addr0", obs_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_req1", 32'(obs_req), 32'd1);
    checkOutput("t1_addr1", obs_addr, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_req2", 32'(obs_req), 32'd1);
    checkOutput("t1_addr2", obs_addr, 32'h8);
    checkOutput("t1_dvalid", 32'(obs_dvalid), 32'd1);
    checkOutput("t1_dpc", obs_dpc, 32'h0);
    checkOutput("t1_dpc4", obs_dpc4, 32'h4);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("t1_stream_req", 32'(obs_req), 32'd1);
      checkOutput("t1_stream_valid", 32'(obs_dvalid), 32'd1);
    end

    // Decode stall: fetch stops with two entries buffered, then drains in order.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("t2_stall_req", 32'(obs_req), 32'd0);
      checkOutput("t2_stall_valid", 32'(obs_dvalid), 32'd1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // 3-cycle memory, redirect in the 2nd wait cycle.
    doReset();
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_req", 32'(obs_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_drop_noreq", 32'(obs_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_req_new", 32'(obs_req), 32'd1);
    checkOutput("t3_addr_new", obs_addr, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      if (obs_dvalid) begin
        seen = 1'b1;
        checkOutput("t3_first_pc", obs_dpc, 32'h200);
      end
    end
    checkOutput("t3_dvalid_seen", 32'(seen), 32'd1);

    // Redirect coincident with a response.
    mem_lat = 1;
    for (int i = 0; i < 8 && !(mem_busy && mem_wait == 0); i++)
      applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_resp_pending", 32'(mem_busy && mem_wait == 0), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h300);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_req", 32'(obs_req), 32'd1);
    checkOutput("t4_addr", obs_addr, 32'h300);
    checkOutput("t4_dvalid", 32'(obs_dvalid), 32'd0);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_addr_top", obs_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_req_wrap", 32'(obs_req), 32'd1);
    checkOutput("t5_addr_wrap", obs_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_dvalid", 32'(obs_dvalid), 32'd1);
    checkOutput("t5_dpc", obs_dpc, 32'hFFFF_FFFC);
    checkOutput("t5_dpc4", obs_dpc4, 32'h0);

    // Misaligned redirect.
    applyStimulus(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("t6_halt_req", 32'(obs_req), 32'd0);
      checkOutput("t6_halt_err", 32'(obs_err), 32'd1);
    end
`else
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t6_req", 32'(obs_req), 32'd1);
    checkOutput("t6_addr", obs_addr, 32'h100);
    checkOutput("t6_err", 32'(obs_err), 32'd0);
`endif

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mem_lat = int'($urandom_range(1, 3));
      r_rdy   = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 24) == 0);
      r_pc    = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      applyStimulus(r_rdy, r_redir, r_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
